// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX/RX slice.
// Holds the state codes, line levels and baud divider helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Flat codes so the state register stays a plain logic vector.
   localparam logic [2:0] ST_IDLE   = IDLE;
   localparam logic [2:0] ST_START  = START;
   localparam logic [2:0] ST_DATA   = DATA;
   localparam logic [2:0] ST_PARITY = PARITY;
   localparam logic [2:0] ST_STOP   = STOP;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;

   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   function automatic int cnt_width(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the UART TX control stage and the serializer.
interface uart_tx_serializer_if;

   logic [7:0] data_in;
   logic       tx_en;
   logic       busy_flag;
   logic       tx_done;
   logic       tx;

   modport master (
      output data_in,
      output tx_en,
      input  busy_flag,
      input  tx_done,
      input  tx
   );

   modport slave (
      input  data_in,
      input  tx_en,
      output busy_flag,
      output tx_done,
      output tx
   );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 while enabled and flags the terminal count.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic bit_tick
);

   localparam int           W    = cnt_width(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign bit_tick = enable && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit(s).
// A request is accepted only when idle; the next one can land the cycle after tx_done.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input logic                 sys_clk,
   input logic                 rst,
   uart_tx_serializer_if.slave bus
);

   localparam int         BAUD_DIV  = baud_div(CLK_FREQ, BAUD);
   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
   localparam logic       ODD_BIT   = (PARITY_ODD != 0);

   logic [2:0] state_q,   state_d;
   logic [7:0] shift_q,   shift_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic       parity_q,  parity_d;
   logic       tx_q,      tx_d;
   logic       busy_q,    busy_d;
   logic       done_q,    done_d;

   logic accept;
   logic bit_tick;

   assign accept = bus.tx_en && !busy_q;

   uart_baud_gen #(
      .DIV(BAUD_DIV)
   ) u_baud_gen (
      .clk     (sys_clk),
      .rst     (rst),
      .clear   (accept),
      .enable  (busy_q),
      .bit_tick(bit_tick)
   );

   // The shift register always presents the next data bit at [0].
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      parity_d  = parity_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d   = LINE_IDLE;
            busy_d = 1'b0;
            if (accept) begin
               state_d   = ST_START;
               shift_d   = bus.data_in;
               parity_d  = (^(bus.data_in & DATA_MASK)) ^ ODD_BIT;
               bit_idx_d = '0;
               tx_d      = LINE_START;
               busy_d    = 1'b1;
            end
         end

         ST_START: begin
            if (bit_tick) begin
               state_d   = ST_DATA;
               tx_d      = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = '0;
            end
         end

         ST_DATA: begin
            if (bit_tick) begin
               if (bit_idx_q == LAST_DATA) begin
                  bit_idx_d = '0;
                  if (PARITY_EN != 0) begin
                     state_d = ST_PARITY;
                     tx_d    = parity_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = LINE_IDLE;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end
         end

         ST_PARITY: begin
            if (bit_tick) begin
               state_d   = ST_STOP;
               tx_d      = LINE_IDLE;
               bit_idx_d = '0;
            end
         end

         ST_STOP: begin
            tx_d = LINE_IDLE;
            if (bit_tick) begin
               if (bit_idx_q == LAST_STOP) begin
                  state_d   = ST_IDLE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end

         default: begin
            state_d   = ST_IDLE;
            tx_d      = LINE_IDLE;
            busy_d    = 1'b0;
            bit_idx_d = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         parity_q  <= 1'b0;
         tx_q      <= LINE_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         parity_q  <= parity_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.tx        = tx_q;
   assign bus.busy_flag = busy_q;
   assign bus.tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 7N2) at BAUD_DIV=16,
// each frame checked cycle by cycle against a bit-list model of the frame.
module tb_uart_tx_serializer;

   logic       sys_clk;
   logic       rst;
   logic [7:0] din [4];
   logic [3:0] en;
   logic [3:0] tx_s;
   logic [3:0] busy_s;
   logic [3:0] done_s;

   int n_checks;
   int n_fail;

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      uart_tx_serializer_if bus ();

      assign bus.data_in = din[g];
      assign bus.tx_en   = en[g];
      assign tx_s[g]     = bus.tx;
      assign busy_s[g]   = bus.busy_flag;
      assign done_s[g]   = bus.tx_done;

      uart_tx_serializer #(
         .CLK_FREQ  (16),
         .BAUD      (1),
         .DATA_BITS ((g == 3) ? 7 : 8),
         .PARITY_EN ((g == 1 || g == 2) ? 1 : 0),
         .PARITY_ODD((g == 2) ? 1 : 0),
         .STOP_BITS ((g == 3) ? 2 : 1)
      ) dut (
         .sys_clk(sys_clk),
         .rst    (rst),
         .bus    (bus)
      );
   end

   function automatic int cfg_db(input int d);
      return (d == 3) ? 7 : 8;
   endfunction

   function automatic bit cfg_pe(input int d);
      return (d == 1 || d == 2);
   endfunction

   function automatic bit cfg_po(input int d);
      return (d == 2);
   endfunction

   function automatic int cfg_sb(input int d);
      return (d == 3) ? 2 : 1;
   endfunction

   task automatic checkOutput(input int d, input logic [2:0] exp, input string name);
      logic [2:0] got;
      got = {tx_s[d], busy_s[d], done_s[d]};
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s dut%0d t=%0t: tx/busy/done got %b, want %b",
                  name, d, $time, got, exp);
      end
   endtask

   task automatic checkValue(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   // Sends one frame on dut d. Pulses p0..p2 are extra tx_en requests at those
   // edge offsets; hold keeps tx_en high and skips the idle cycle so the next
   // call lands back-to-back; abort_at returns mid-frame after that cycle.
   task automatic applyStimulus(input int d, input logic [7:0] data,
                                input int p0, input int p1, input int p2,
                                input bit hold, input int abort_at,
                                output int busy_len, output logic par_bit);
      logic       fb [12];
      int         nb;
      int         ones;
      int         n;
      int         db;
      logic [7:0] decoded;
      logic [7:0] exp_data;

      db   = cfg_db(d);
      nb   = 0;
      ones = 0;
      fb[nb] = 1'b0;
      nb++;
      for (int i = 0; i < db; i++) begin
         fb[nb] = data[i];
         nb++;
         ones += int'(data[i]);
      end
      if (cfg_pe(d)) begin
         fb[nb] = ((ones % 2) == 1) ^ cfg_po(d);
         nb++;
      end
      for (int i = 0; i < cfg_sb(d); i++) begin
         fb[nb] = 1'b1;
         nb++;
      end
      n = nb * 16;

      exp_data = 8'h00;
      for (int i = 0; i < db; i++) exp_data[i] = data[i];

      din[d] = data;
      en[d]  = 1'b1;
      @(posedge sys_clk);
      #1;
      en[d]  = hold;
      din[d] = 8'($urandom);

      busy_len = 0;
      par_bit  = 1'b0;
      decoded  = 8'h00;
      for (int t = 0; t < n; t++) begin
         checkOutput(d, {fb[t / 16], 1'b1, 1'b0}, "frame_cycle");
         if (busy_s[d]) busy_len++;
         if ((t % 16) == 8 && (t / 16) >= 1 && (t / 16) <= db) decoded[t / 16 - 1] = tx_s[d];
         if (t == (1 + db) * 16 + 8) par_bit = tx_s[d];
         if (abort_at != 0 && t == abort_at) return;
         if (!hold) en[d] = (t + 1 == p0) || (t + 1 == p1) || (t + 1 == p2);
         @(posedge sys_clk);
         #1;
      end
      checkOutput(d, 3'b101, "frame_done");
      checkValue("decoded_byte", int'(decoded), int'(exp_data));
      if (!hold) begin
         en[d] = 1'b0;
         @(posedge sys_clk);
         #1;
         checkOutput(d, 3'b100, "idle_after_done");
      end
   endtask

   typedef struct {
      int         dut;
      logic [7:0] data;
      bit         check_parity;
      logic       exp_parity;
      int         exp_len;
      string      name;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int   blen;
      logic pbit;

      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      en       = 4'b0000;
      for (int i = 0; i < 4; i++) din[i] = 8'h00;

      vecs[0] = '{0, 8'h41, 1'b0, 1'b0, 160, "8N1_0x41"};
      vecs[1] = '{1, 8'h41, 1'b1, 1'b0, 176, "8E1_0x41"};
      vecs[2] = '{2, 8'h41, 1'b1, 1'b1, 176, "8O1_0x41"};
      vecs[3] = '{1, 8'h43, 1'b1, 1'b1, 176, "8E1_0x43"};
      vecs[4] = '{3, 8'hFF, 1'b0, 1'b0, 160, "7N2_0xFF"};

      repeat (3) @(posedge sys_clk);
      #1;
      for (int d = 0; d < 4; d++) checkOutput(d, 3'b100, "in_reset");
      rst = 1'b0;
      @(posedge sys_clk);
      #1;
      for (int d = 0; d < 4; d++) checkOutput(d, 3'b100, "after_reset");

      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].dut, vecs[v].data, 0, 0, 0, 1'b0, 0, blen, pbit);
         checkValue({vecs[v].name, "_length"}, blen, vecs[v].exp_len);
         if (vecs[v].check_parity)
            checkValue({vecs[v].name, "_parity"}, int'(pbit), int'(vecs[v].exp_parity));
      end

      applyStimulus(0, 8'h41, 5, 80, 160, 1'b0, 0, blen, pbit);
      checkValue("ignored_requests_length", blen, 160);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 8'(8'h41 + i), 0, 0, 0, (i < 3), 0, blen, pbit);
      end

      for (int r = 0; r < 8; r++) begin
         int         d;
         logic [7:0] data;
         d    = $urandom_range(0, 3);
         data = 8'($urandom);
         applyStimulus(d, data, $urandom_range(1, 150), 0, 0, 1'b0, 0, blen, pbit);
         repeat ($urandom_range(0, 3)) begin
            @(posedge sys_clk);
            #1;
            checkOutput(d, 3'b100, "random_gap_idle");
         end
      end

      applyStimulus(0, 8'($urandom), 0, 0, 0, 1'b0, 50, blen, pbit);
      #2;
      rst = 1'b1;
      #1;
      checkOutput(0, 3'b100, "async_reset_midframe");
      @(posedge sys_clk);
      #1;
      checkOutput(0, 3'b100, "held_in_reset");
      rst = 1'b0;
      applyStimulus(0, 8'h55, 0, 0, 0, 1'b0, 0, blen, pbit);
      checkValue("post_reset_length", blen, 160);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit serializer. Sits directly downstream of the UART TX control stage, which presents a byte and a one-cycle enable.
- Frames the byte as start bit, data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Drives the serial line and reports busy and done status back to the control stage.
- Baud timing is derived from the system clock by an integer divider.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (integer, truncating), must be >= 2
DATA_BITS, 8, data bits per frame, legal range 5..8
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
sys_clk  input  1  system clock, all logic on its rising edge
rst  input  1  reset, asynchronous, active-high
data_in  input  8  byte to send; bits [DATA_BITS-1:0] are used
tx_en  input  1  send request, sampled every cycle
busy_flag  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse when a frame completes
tx  output  1  serial line, idle high, driven from a register

Interface decision: one clock (sys_clk); reset (rst) is asynchronous and active-high.

Behaviour:
- Reset: state IDLE, tx=1, busy_flag=0, tx_done=0, baud counter=0, bit index=0, shift register=0.
  - Reset asserted mid-frame aborts the frame immediately; tx returns to 1 asynchronously.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
- Frame length: N = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * BAUD_DIV cycles.
- Accept: at an edge k where tx_en=1 and busy_flag=0:
  - latch data_in into the shift register;
  - compute parity = XOR of the data bits, inverted if PARITY_ODD;
  - go to START, tx=0, busy_flag=1, baud counter cleared.
  - All of these are visible after edge k, so latency from request to start bit is one cycle.
- Ignored requests: tx_en while busy_flag=1 is ignored (no queueing). data_in changes after acceptance do not affect the frame in progress.
- Bit timing:
  - Each bit is held for exactly BAUD_DIV cycles.
  - The baud counter counts 0..BAUD_DIV-1; the terminal count advances to the next bit or state.
  - DATA shifts out LSB first; the bit index runs 0..DATA_BITS-1.
  - STOP holds tx=1 for STOP_BITS*BAUD_DIV cycles.
- Completion: at edge k+N the state returns to IDLE, busy_flag=0 and tx_done=1 for exactly one cycle. tx stays 1.
- Back-to-back: tx_en=1 at edge k+N is ignored because busy_flag is still 1 before that edge. The earliest next acceptance is edge k+N+1, giving a minimum frame-to-frame spacing of N+1 cycles with no glitch on tx.
- tx_en held high continuously therefore produces frames every N+1 cycles.
- Illegal states decode to IDLE with tx=1.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/PARITY/STOP);
  - constant function for BAUD_DIV;
  - counter width as clog2(BAUD_DIV);
  - line level constants (IDLE=1, START=0).
- One sub-module, uart_baud_gen:
  - counter with clear and enable;
  - outputs a one-cycle bit_tick at terminal count;
  - the parent clears it on accept and enables it while busy.
- The RX side reuses the same package and sub-module.

Test Plan:
1. CLK_FREQ=16, BAUD=1 (BAUD_DIV=16), 8N1, data_in=0x41, one-cycle tx_en -> busy_flag rises 1 cycle later; tx is 0 for 16 cycles, then 1,0,0,0,0,0,1,0 (16 cycles each), then 1 for 16 cycles; tx_done pulses at cycle 160 with busy_flag falling in the same cycle.
2. PARITY_EN=1: data_in=0x41 with PARITY_ODD=0 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; data_in=0x43 even -> parity bit 1; frame length 176 cycles.
3. tx_en pulsed at cycles 5, 80 and 160 of a frame carrying 0x41 -> all three ignored; the line carries only 0x41 and exactly one tx_done pulse occurs.
4. tx_en held high, data_in 'A','B','C','D' changed on each tx_done -> four frames spaced 161 cycles apart; decoded bytes 0x41, 0x42, 0x43, 0x44.
5. STOP_BITS=2, DATA_BITS=7, data_in=0xFF -> 7 data ones, stop high for 32 cycles, frame 160 cycles total; bit 7 is never transmitted.
6. rst asserted at cycle 50 of a frame -> tx=1, busy_flag=0, tx_done=0 immediately; after release, a new tx_en with 0x55 produces a clean frame starting one cycle later.
